block_sf_192_demux: RTL and testbench
=====================================

Name: block_sf_192_demux

Overview:
- Receive-side counterpart of the 192 kHz stereo matrix block.
- Accepts a time-multiplexed stream of sum (L+R) and difference (L−R) samples on one 18-bit bus, pairs each sum with the following difference, and reconstructs 18-bit LEFT/RIGHT at the 192 kHz frame rate.
- Sits between the composite sample source and the audio output/DAC path.
- Flags out-of-order tags and stalled frames.

Parameters:
- DW, 18, sample width in bits (signed two's complement) for input and outputs.
- TIMEOUT, 512, clock cycles allowed between an accepted sum and its difference before the frame is abandoned; minimum 2.
- TW, 10, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state immediately.
- in_valid  in  1  in_data/in_tag valid this cycle; the block is always ready (no backpressure).
- in_data  in  DW  signed sample.
- in_tag  in  1  0 = sum sample (L+R), 1 = difference sample (L−R).
- LEFT  out  DW  reconstructed left sample; holds between updates.
- RIGHT  out  DW  reconstructed right sample; holds between updates.
- out_valid  out  1  one-cycle pulse when LEFT/RIGHT have just updated.
- pair_err  out  1  one-cycle pulse on an out-of-order tag.
- timeout_err  out  1  one-cycle pulse when a pending frame is abandoned.

Behaviour:
- Reset (reset=0, asynchronous):
  - LEFT=0, RIGHT=0, out_valid=0, pair_err=0, timeout_err=0.
  - FSM goes to WAIT_SUM; timer=0; sum register=0; stage-1 valid=0.
  - Reset mid-frame discards any pending sum and any in-flight result: no out_valid after release.
- FSM WAIT_SUM:
  - in_valid & tag=0: latch S=in_data, clear timer, go HAVE_SUM.
  - in_valid & tag=1: discard the sample, pulse pair_err next cycle, stay.
  - No valid: stay; timer held at 0.
- FSM HAVE_SUM:
  - in_valid & tag=1: latch D=in_data, set stage-1 valid, go WAIT_SUM.
  - in_valid & tag=0: replace S with the new sample, clear timer, pulse pair_err, stay.
  - No valid: timer+1. When timer == TIMEOUT−1 with no valid this cycle: go WAIT_SUM, pulse timeout_err, clear timer.
  - Simultaneous timeout and in_valid: in_valid wins and is handled as above; no timeout_err.
- Arithmetic (stage 2, registered):
  - L = (S + D) >>> 1, R = (S − D) >>> 1, with sums formed at DW+1 bits.
  - Arithmetic shift (floor toward −inf). The result always fits in DW bits, so no saturation is needed; truncate to the low DW bits.
- Latency:
  - Difference sampled at edge k; LEFT/RIGHT updated at edge k+1.
  - out_valid is high for exactly the cycle following edge k+1.
  - Back-to-back frames (sum, diff, sum, diff on consecutive cycles) must be sustained at one output per 2 cycles.
- Error pulses are registered: high for the cycle after the offending edge. They never coincide with reset.
- Outputs hold their last values indefinitely when no frames arrive.

Decomposition:
- Package sf_192_pkg:
  - TAG_SUM=1'b0, TAG_DIFF=1'b1.
  - FSM state encoding (WAIT_SUM, HAVE_SUM).
  - Default DW=18.
- Sub-module sf_192_matrix_dec:
  - Registered stage taking S, D and valid; producing L, R and out_valid with the arithmetic above.
  - Shareable with the transmit-side matrix tests.
- The top holds the FSM, timer and error logic.

Test Plan:
- Basic pairing: (tag0, 1000) then (tag1, 200) on consecutive cycles → LEFT=600, RIGHT=400, out_valid one cycle, 2 cycles after the diff.
- Extremes and rounding:
  - S=−131072, D=−131072 → L=−131072, R=0.
  - S=131071, D=−131072 → L=−1, R=131071.
  - S=3, D=0 → L=1, R=1.
  - S=−3, D=0 → L=−2, R=−2.
- Ordering errors:
  - Diff first → pair_err pulse, no out_valid.
  - Sum 50, sum 70, diff 10 → one pair_err; output L=40, R=30.
- Timeout (TIMEOUT=8):
  - Sum then 8 idle cycles → timeout_err pulse; a later diff gives pair_err and no output.
  - Diff arriving on the 8th idle cycle → normal output, no timeout_err.
- Reset: assert reset the cycle after a diff is accepted → out_valid never asserts; LEFT/RIGHT=0 immediately, asynchronously.
- Throughput: 100 random back-to-back frames → 100 out_valid pulses, each spaced 2 cycles apart, matching the reference model.

Source files
------------

// File: rtl/sf_192_pkg.sv
// Shared constants for the 192 kHz stereo matrix receive path: tag values,
// FSM encoding and default sample width.
package sf_192_pkg;

    localparam int SF_DW = 18;

    localparam logic TAG_SUM  = 1'b0;
    localparam logic TAG_DIFF = 1'b1;

    localparam logic [0:0] WAIT_SUM = 1'b0;
    localparam logic [0:0] HAVE_SUM = 1'b1;

endpackage

// File: rtl/sf_192_matrix_dec.sv
// Registered sum/difference to left/right decode; outputs hold between frames.
module sf_192_matrix_dec
    import sf_192_pkg::*;
#(
    parameter int DW = SF_DW
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] s_in,
    input  logic signed [DW-1:0] d_in,
    output logic signed [DW-1:0] l_out,
    output logic signed [DW-1:0] r_out,
    output logic                 out_valid
);

    logic signed [DW:0]   add_w;
    logic signed [DW:0]   sub_w;
    logic signed [DW-1:0] l_d, l_q;
    logic signed [DW-1:0] r_d, r_q;
    logic                 v_d, v_q;

    // One guard bit keeps S+D and S-D exact; halving brings it back into DW bits.
    always_comb begin
        add_w = {s_in[DW-1], s_in} + {d_in[DW-1], d_in};
        sub_w = {s_in[DW-1], s_in} - {d_in[DW-1], d_in};
        l_d   = l_q;
        r_d   = r_q;
        v_d   = in_valid;
        if (in_valid) begin
            l_d = DW'(add_w >>> 1);
            r_d = DW'(sub_w >>> 1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            l_q <= '0;
            r_q <= '0;
            v_q <= 1'b0;
        end else begin
            l_q <= l_d;
            r_q <= r_d;
            v_q <= v_d;
        end
    end

    assign l_out     = l_q;
    assign r_out     = r_q;
    assign out_valid = v_q;

endmodule

// File: rtl/block_sf_192_demux.sv
// Pairs a multiplexed sum/difference stream into frames and reconstructs
// LEFT/RIGHT; flags out-of-order tags and sums left waiting too long.
module block_sf_192_demux
    import sf_192_pkg::*;
#(
    parameter int DW      = SF_DW,
    parameter int TIMEOUT = 512,
    parameter int TW      = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] in_data,
    input  logic                 in_tag,
    output logic signed [DW-1:0] LEFT,
    output logic signed [DW-1:0] RIGHT,
    output logic                 out_valid,
    output logic                 pair_err,
    output logic                 timeout_err
);

    logic [0:0]           state_d, state_q;
    logic [TW-1:0]        timer_d, timer_q;
    logic signed [DW-1:0] sum_d, sum_q;
    logic signed [DW-1:0] diff_d, diff_q;
    logic                 v1_d, v1_q;
    logic                 pair_err_d, pair_err_q;
    logic                 timeout_err_d, timeout_err_q;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        sum_d         = sum_q;
        diff_d        = diff_q;
        v1_d          = 1'b0;
        pair_err_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            WAIT_SUM: begin
                timer_d = '0;
                if (in_valid) begin
                    if (in_tag == TAG_SUM) begin
                        sum_d   = in_data;
                        state_d = HAVE_SUM;
                    end else begin
                        pair_err_d = 1'b1;
                    end
                end
            end
            HAVE_SUM: begin
                // A valid sample always takes priority over an expiring timer.
                if (in_valid) begin
                    timer_d = '0;
                    if (in_tag == TAG_DIFF) begin
                        diff_d  = in_data;
                        v1_d    = 1'b1;
                        state_d = WAIT_SUM;
                    end else begin
                        sum_d      = in_data;
                        pair_err_d = 1'b1;
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timer_d       = '0;
                    timeout_err_d = 1'b1;
                    state_d       = WAIT_SUM;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = WAIT_SUM;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= WAIT_SUM;
            timer_q       <= '0;
            sum_q         <= '0;
            diff_q        <= '0;
            v1_q          <= 1'b0;
            pair_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            sum_q         <= sum_d;
            diff_q        <= diff_d;
            v1_q          <= v1_d;
            pair_err_q    <= pair_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // sum_q may be overwritten on the decode edge by the next frame's sum;
    // the decoder samples the old value on that same edge.
    sf_192_matrix_dec #(.DW(DW)) u_dec (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (v1_q),
        .s_in      (sum_q),
        .d_in      (diff_q),
        .l_out     (LEFT),
        .r_out     (RIGHT),
        .out_valid (out_valid)
    );

    assign pair_err    = pair_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_block_sf_192_demux.sv
// Directed bench for block_sf_192_demux with TIMEOUT=8.
module tb_block_sf_192_demux;

    logic                clock;
    logic                reset;
    logic                in_valid;
    logic signed [17:0]  in_data;
    logic                in_tag;
    logic signed [17:0]  LEFT;
    logic signed [17:0]  RIGHT;
    logic                out_valid;
    logic                pair_err;
    logic                timeout_err;

    int n_assert = 0;
    int n_fail   = 0;

    block_sf_192_demux #(.DW(18), .TIMEOUT(8), .TW(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_tag      (in_tag),
        .LEFT        (LEFT),
        .RIGHT       (RIGHT),
        .out_valid   (out_valid),
        .pair_err    (pair_err),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then return 1 time unit after the sampling edge.
    task automatic cyc(input logic v, input logic t, input logic signed [17:0] d);
        in_valid = v;
        in_tag   = t;
        in_data  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 18'sd0);
    endtask

    task automatic frame(input string tag, input logic signed [17:0] s, input logic signed [17:0] d,
                         input int exp_l, input int exp_r);
        cyc(1'b1, 1'b0, s);
        cyc(1'b1, 1'b1, d);
        chk({tag, "_ov_early"}, out_valid, 0);
        idle();
        chk({tag, "_ov"}, out_valid, 1);
        chk({tag, "_left"}, LEFT, exp_l);
        chk({tag, "_right"}, RIGHT, exp_r);
        idle();
        chk({tag, "_ov_pulse"}, out_valid, 0);
    endtask

    initial begin
        logic signed [17:0] rs [100];
        logic signed [17:0] rd [100];
        int el [100];
        int er [100];
        int pulses;
        int si, di;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_tag   = 1'b0;
        in_data  = '0;
        #3;
        chk("rst_left", LEFT, 0);
        chk("rst_right", RIGHT, 0);
        chk("rst_ov", out_valid, 0);
        chk("rst_perr", pair_err, 0);
        chk("rst_terr", timeout_err, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle();

        frame("basic", 18'sd1000, 18'sd200, 600, 400);
        frame("ext_neg", -18'sd131072, -18'sd131072, -131072, 0);
        frame("ext_mix", 18'sd131071, -18'sd131072, -1, 131071);
        frame("rnd_pos", 18'sd3, 18'sd0, 1, 1);
        frame("rnd_neg", -18'sd3, 18'sd0, -2, -2);

        // difference with no pending sum
        cyc(1'b1, 1'b1, 18'sd5);
        chk("dfirst_perr", pair_err, 1);
        idle();
        chk("dfirst_perr_clr", pair_err, 0);
        chk("dfirst_ov", out_valid, 0);
        chk("dfirst_hold_l", LEFT, -2);

        // second sum replaces the first
        cyc(1'b1, 1'b0, 18'sd50);
        chk("ss_perr0", pair_err, 0);
        cyc(1'b1, 1'b0, 18'sd70);
        chk("ss_perr1", pair_err, 1);
        cyc(1'b1, 1'b1, 18'sd10);
        chk("ss_perr2", pair_err, 0);
        idle();
        chk("ss_ov", out_valid, 1);
        chk("ss_left", LEFT, 40);
        chk("ss_right", RIGHT, 30);
        idle();

        // abandoned frame after 8 idle cycles
        cyc(1'b1, 1'b0, 18'sd100);
        for (int i = 0; i < 7; i++) begin
            idle();
            chk("to_early", timeout_err, 0);
        end
        idle();
        chk("to_pulse", timeout_err, 1);
        cyc(1'b1, 1'b1, 18'sd4);
        chk("to_clr", timeout_err, 0);
        chk("to_late_perr", pair_err, 1);
        idle();
        chk("to_late_ov", out_valid, 0);
        idle();

        // difference arrives on the 8th idle cycle: valid beats the timer
        cyc(1'b1, 1'b0, 18'sd20);
        for (int i = 0; i < 7; i++) idle();
        cyc(1'b1, 1'b1, 18'sd6);
        chk("edge_terr", timeout_err, 0);
        chk("edge_perr", pair_err, 0);
        idle();
        chk("edge_ov", out_valid, 1);
        chk("edge_left", LEFT, 13);
        chk("edge_right", RIGHT, 7);
        chk("edge_terr2", timeout_err, 0);
        idle();

        // reset asserted while a result is in flight
        cyc(1'b1, 1'b0, 18'sd300);
        cyc(1'b1, 1'b1, 18'sd100);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_left", LEFT, 0);
        chk("arst_right", RIGHT, 0);
        chk("arst_ov", out_valid, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            idle();
            if (out_valid) pulses++;
        end
        chk("arst_no_ov", pulses, 0);

        // 100 back-to-back frames
        for (int i = 0; i < 100; i++) begin
            rs[i] = 18'($urandom_range(0, 262143));
            rd[i] = 18'($urandom_range(0, 262143));
            si = rs[i];
            di = rd[i];
            el[i] = (si + di) >>> 1;
            er[i] = (si - di) >>> 1;
        end
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1'b1, 1'b0, rs[i]);
            if (i > 0) begin
                if (out_valid) pulses++;
                chk("tp_ov", out_valid, 1);
                chk("tp_left", LEFT, el[i-1]);
                chk("tp_right", RIGHT, er[i-1]);
            end
            cyc(1'b1, 1'b1, rd[i]);
            if (out_valid) pulses++;
            chk("tp_gap", out_valid, 0);
        end
        idle();
        if (out_valid) pulses++;
        chk("tp_last_left", LEFT, el[99]);
        chk("tp_last_right", RIGHT, er[99]);
        idle();
        if (out_valid) pulses++;
        chk("tp_pulses", pulses, 100);
        chk("tp_perr", pair_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
